// File: rtl/neurocore_pkg.sv
// Shared defaults and FSM state type for the neurocore matrix datapath blocks.
package neurocore_pkg;

  localparam int NC_DATA_W = 16;
  localparam int NC_J      = 4;
  localparam int NC_K      = 4;
  localparam int NC_DIM_W  = 10;
  localparam int NC_ADDR_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/block_fetch_tag_pipe.sv
// Delays the per-slot capture tag {valid, pad, slot} by the memory read latency.
module block_fetch_tag_pipe #(
  parameter int W     = 4,
  parameter int DEPTH = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] tag_in,
  output logic [W-1:0] tag_out
);

  logic [W-1:0] stage_q [DEPTH];
  logic [W-1:0] stage_d [DEPTH];

  always_comb begin
    stage_d[0] = tag_in;
    for (int k = 1; k < DEPTH; k++) stage_d[k] = stage_q[k-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) stage_q[k] <= '0;
    end else begin
      for (int k = 0; k < DEPTH; k++) stage_q[k] <= stage_d[k];
    end
  end

  assign tag_out = stage_q[DEPTH-1];

endmodule

// File: rtl/block_fetch.sv
// Sequential J x K tile fetcher: one read per cycle from a synchronous-read matrix RAM,
// zero-padding out-of-bounds elements, optional transpose when the tile is square.
module block_fetch
  import neurocore_pkg::*;
#(
  parameter int DATA_W = NC_DATA_W,
  parameter int J      = NC_J,
  parameter int K      = NC_K,
  parameter int DIM_W  = NC_DIM_W,
  parameter int ADDR_W = NC_ADDR_W,
  parameter int RD_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  transpose,
  input  logic [ADDR_W-1:0]     base_addr,
  input  logic [DIM_W-1:0]      start_row,
  input  logic [DIM_W-1:0]      start_col,
  input  logic [DIM_W-1:0]      num_rows,
  input  logic [DIM_W-1:0]      num_cols,
  output logic                  mem_en,
  output logic [ADDR_W-1:0]     mem_addr,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic                  busy,
  output logic                  done,
  output logic [J*K*DATA_W-1:0] block,
  output fetch_state_e          dbg_state
);

  localparam int  N      = J * K;
  localparam int  SLOT_W = (N > 1) ? $clog2(N) : 1;
  localparam int  CW     = (K > 1) ? $clog2(K) : 1;
  localparam int  DRW    = $clog2(RD_LAT + 1);
  localparam int  TAG_W  = SLOT_W + 2;
  localparam bit  TR_OK  = (J == K);
  localparam logic [DIM_W:0] RC_ONE = 1;

  // Handshake: start is a level request accepted only on an edge where the FSM is
  // IDLE; busy covers ISSUE..DONE, and done pulses for exactly the DONE cycle.
  fetch_state_e        state_q, state_d;
  logic [SLOT_W-1:0]   slot_q, slot_d;
  logic [CW-1:0]       j_q, j_d;
  logic [DRW-1:0]      drain_q, drain_d;
  logic                tr_q, tr_d;
  logic [DIM_W-1:0]    nrows_q, nrows_d, ncols_q, ncols_d;
  logic [DIM_W:0]      srow_q, srow_d, scol_q, scol_d;
  logic [DIM_W:0]      r_q, r_d, c_q, c_d;
  logic [ADDR_W-1:0]   addr_cur_q, addr_cur_d;
  logic [ADDR_W-1:0]   outer_base_q, outer_base_d;
  logic [ADDR_W-1:0]   addr_hold_q, addr_hold_d;
  logic [N*DATA_W-1:0] block_q, block_d;

  logic                issue, inb;
  logic [ADDR_W-1:0]   inner_step, outer_step, origin_addr;
  logic [2*DIM_W-1:0]  origin_prod;
  logic [TAG_W-1:0]    tag_in, tag_out;
  logic                cap_valid, cap_pad;
  logic [SLOT_W-1:0]   cap_slot;

  assign issue = (state_q == ST_ISSUE);
  assign inb   = (r_q < {1'b0, nrows_q}) && (c_q < {1'b0, ncols_q});

  assign mem_en    = issue && inb;
  assign mem_addr  = mem_en ? addr_cur_q : addr_hold_q;
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign block     = block_q;
  assign dbg_state = state_q;

  // Origin offset is formed once per accept; every later step is add-only.
  assign origin_prod = {{DIM_W{1'b0}}, start_row} * {{DIM_W{1'b0}}, num_cols};
  assign origin_addr = base_addr + ADDR_W'(origin_prod) + ADDR_W'(start_col);

  assign inner_step = tr_q ? ADDR_W'(ncols_q) : ADDR_W'(1);
  assign outer_step = tr_q ? ADDR_W'(1) : ADDR_W'(ncols_q);

  assign tag_in = {issue, ~inb, slot_q};
  assign {cap_valid, cap_pad, cap_slot} = tag_out;

  block_fetch_tag_pipe #(
    .W     (TAG_W),
    .DEPTH (RD_LAT)
  ) u_tag_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

  always_comb begin
    state_d      = state_q;
    slot_d       = slot_q;
    j_d          = j_q;
    drain_d      = drain_q;
    tr_d         = tr_q;
    nrows_d      = nrows_q;
    ncols_d      = ncols_q;
    srow_d       = srow_q;
    scol_d       = scol_q;
    r_d          = r_q;
    c_d          = c_q;
    addr_cur_d   = addr_cur_q;
    outer_base_d = outer_base_q;
    addr_hold_d  = addr_hold_q;
    block_d      = block_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d      = ST_ISSUE;
          slot_d       = '0;
          j_d          = '0;
          tr_d         = transpose && TR_OK;
          nrows_d      = num_rows;
          ncols_d      = num_cols;
          srow_d       = {1'b0, start_row};
          scol_d       = {1'b0, start_col};
          r_d          = {1'b0, start_row};
          c_d          = {1'b0, start_col};
          addr_cur_d   = origin_addr;
          outer_base_d = origin_addr;
          block_d      = '0;
        end
      end
      ST_ISSUE: begin
        if (mem_en) addr_hold_d = addr_cur_q;
        slot_d = slot_q + SLOT_W'(1);
        // Inner index walks columns (rows when transposed); outer index resets it.
        if (j_q == CW'(K - 1)) begin
          j_d          = '0;
          outer_base_d = outer_base_q + outer_step;
          addr_cur_d   = outer_base_q + outer_step;
          if (tr_q) begin
            c_d = c_q + RC_ONE;
            r_d = srow_q;
          end else begin
            r_d = r_q + RC_ONE;
            c_d = scol_q;
          end
        end else begin
          j_d        = j_q + CW'(1);
          addr_cur_d = addr_cur_q + inner_step;
          if (tr_q) r_d = r_q + RC_ONE;
          else      c_d = c_q + RC_ONE;
        end
        if (slot_q == SLOT_W'(N - 1)) begin
          state_d = ST_DRAIN;
          drain_d = '0;
        end
      end
      ST_DRAIN: begin
        if (drain_q == DRW'(RD_LAT - 1)) state_d = ST_DONE;
        else                             drain_d = drain_q + DRW'(1);
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (cap_valid) begin
      block_d[int'(cap_slot)*DATA_W +: DATA_W] = cap_pad ? '0 : mem_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      slot_q       <= '0;
      j_q          <= '0;
      drain_q      <= '0;
      tr_q         <= 1'b0;
      nrows_q      <= '0;
      ncols_q      <= '0;
      srow_q       <= '0;
      scol_q       <= '0;
      r_q          <= '0;
      c_q          <= '0;
      addr_cur_q   <= '0;
      outer_base_q <= '0;
      addr_hold_q  <= '0;
      block_q      <= '0;
    end else begin
      state_q      <= state_d;
      slot_q       <= slot_d;
      j_q          <= j_d;
      drain_q      <= drain_d;
      tr_q         <= tr_d;
      nrows_q      <= nrows_d;
      ncols_q      <= ncols_d;
      srow_q       <= srow_d;
      scol_q       <= scol_d;
      r_q          <= r_d;
      c_q          <= c_d;
      addr_cur_q   <= addr_cur_d;
      outer_base_q <= outer_base_d;
      addr_hold_q  <= addr_hold_d;
      block_q      <= block_d;
    end
  end

endmodule

// File: tb/tb_block_fetch.sv
// Bench for block_fetch (2x2 tile, read latency 1): per-cycle model check plus literal pins.
module tb_block_fetch;

  localparam int DATA_W = 16;
  localparam int J      = 2;
  localparam int K      = 2;
  localparam int DIM_W  = 10;
  localparam int ADDR_W = 16;
  localparam int RD_LAT = 1;
  localparam int N      = J * K;
  localparam int BW     = N * DATA_W;
  localparam int EW     = ADDR_W + 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic                 start = 1'b0;
  logic                 transpose = 1'b0;
  logic [ADDR_W-1:0]    base_addr = '0;
  logic [DIM_W-1:0]     start_row = '0;
  logic [DIM_W-1:0]     start_col = '0;
  logic [DIM_W-1:0]     num_rows = '0;
  logic [DIM_W-1:0]     num_cols = '0;
  logic                 mem_en;
  logic [ADDR_W-1:0]    mem_addr;
  logic [DATA_W-1:0]    mem_rdata;
  logic                 busy;
  logic                 done;
  logic [BW-1:0]        block;
  neurocore_pkg::fetch_state_e dbg_state;

  block_fetch #(
    .DATA_W (DATA_W), .J (J), .K (K), .DIM_W (DIM_W), .ADDR_W (ADDR_W), .RD_LAT (RD_LAT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .transpose (transpose),
    .base_addr (base_addr),
    .start_row (start_row),
    .start_col (start_col),
    .num_rows  (num_rows),
    .num_cols  (num_cols),
    .mem_en    (mem_en),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .busy      (busy),
    .done      (done),
    .block     (block),
    .dbg_state (dbg_state)
  );

  // Matrix 3x3 at address 0 holds M[r][c] = 10r+c+1; elsewhere a scrambled pattern.
  function automatic logic [DATA_W-1:0] mem_val(input logic [ADDR_W-1:0] a);
    int ai;
    ai = int'(a);
    if (ai < 9) return DATA_W'(10 * (ai / 3) + (ai % 3) + 1);
    return a ^ 16'h5A5A;
  endfunction

  logic [DATA_W-1:0] rd_q = '0;
  always @(posedge clk) if (mem_en) rd_q <= mem_val(mem_addr);
  assign mem_rdata = rd_q;

  // ---------------- scoreboard state ----------------
  // entry: {chk_block, done, busy, en, addr}
  logic [EW-1:0]     exp_q[$];
  logic [BW-1:0]     exp_block = '0;
  logic [ADDR_W-1:0] last_addr = '0;
  logic              prev_done = 1'b0;
  logic [ADDR_W-1:0] seen_q[$];
  int                done_cnt = 0;
  int                cyc = 0;
  int                total = 0;
  int                bad = 0;

  task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Tile model: walk the slots in order and derive reads/padding straight from coordinates.
  task automatic model_push(input logic [ADDR_W-1:0] b, input int sr, input int sc,
                            input int nr, input int nc, input bit tr);
    logic [BW-1:0]     blk;
    logic [ADDR_W-1:0] ad;
    int r, c, i, j;
    bit inb;
    blk = '0;
    for (int s = 0; s < N; s++) begin
      i = s / K;
      j = s % K;
      if (tr) begin r = sr + j; c = sc + i; end
      else    begin r = sr + i; c = sc + j; end
      inb = (r < nr) && (c < nc);
      if (inb) begin
        ad = b + ADDR_W'(r * nc + c);
        last_addr = ad;
        blk[s*DATA_W +: DATA_W] = mem_val(ad);
      end
      exp_q.push_back({1'b0, 1'b0, 1'b1, inb, last_addr});
    end
    for (int d = 0; d < RD_LAT; d++) exp_q.push_back({1'b0, 1'b0, 1'b1, 1'b0, last_addr});
    exp_q.push_back({1'b1, 1'b1, 1'b1, 1'b0, last_addr});
    exp_block = blk;
  endtask

  // ---------------- compare process ----------------
  always @(posedge clk) begin
    logic [EW-1:0] e;
    cyc++;
    #1;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    else                  e = {1'b1, 1'b0, 1'b0, 1'b0, last_addr};
    check("mem_en", BW'(mem_en), BW'(e[ADDR_W]));
    check("mem_addr", BW'(mem_addr), BW'(e[ADDR_W-1:0]));
    check("busy", BW'(busy), BW'(e[ADDR_W+1]));
    check("done", BW'(done), BW'(e[ADDR_W+2]));
    if (e[ADDR_W+3]) check("block", block, exp_block);
    prev_done = e[ADDR_W+2];
    if (done === 1'b1) done_cnt++;
    if (mem_en === 1'b1) seen_q.push_back(mem_addr);
  end

  // ---------------- driver tasks ----------------
  task automatic drive_req(input logic [ADDR_W-1:0] b, input int sr, input int sc,
                           input int nr, input int nc, input bit tr);
    base_addr = b;
    start_row = DIM_W'(sr);
    start_col = DIM_W'(sc);
    num_rows  = DIM_W'(nr);
    num_cols  = DIM_W'(nc);
    transpose = tr;
    start     = 1'b1;
    if (exp_q.size() == 0 && !prev_done) model_push(b, sr, sc, nr, nc, tr);
  endtask

  task automatic scramble_inputs();
    base_addr = ADDR_W'($urandom_range(0, 65535));
    start_row = DIM_W'($urandom_range(0, 1023));
    start_col = DIM_W'($urandom_range(0, 1023));
    num_rows  = DIM_W'($urandom_range(0, 1023));
    num_cols  = DIM_W'($urandom_range(0, 1023));
    transpose = ~transpose;
  endtask

  // Returns the done cycle relative to the accept edge (-1 on timeout).
  task automatic do_fetch(input logic [ADDR_W-1:0] b, input int sr, input int sc,
                          input int nr, input int nc, input bit tr, output int dcyc);
    int t;
    @(negedge clk);
    seen_q.delete();
    drive_req(b, sr, sc, nr, nc, tr);
    t = cyc + 1;
    @(negedge clk);
    start = 1'b0;
    scramble_inputs();
    dcyc = -1;
    for (int k = 0; k < 40 && dcyc < 0; k++) begin
      @(posedge clk);
      #2;
      if (done === 1'b1) dcyc = cyc + 1 - t;
    end
    check("done_seen", BW'(dcyc >= 0), BW'(1));
    @(negedge clk);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int dc, d0;
    logic [BW-1:0] lit;

    #1;
    check("rst_busy", BW'(busy), '0);
    check("rst_block", block, '0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // origin (0,0)
    do_fetch(16'd0, 0, 0, 3, 3, 1'b0, dc);
    check("t1_done_cyc", BW'(dc), BW'(6));
    lit = {16'd12, 16'd11, 16'd2, 16'd1};
    check("t1_block", block, lit);
    check("t1_nreads", BW'(seen_q.size()), BW'(4));
    if (seen_q.size() == 4) begin
      check("t1_addr0", BW'(seen_q[0]), BW'(0));
      check("t1_addr1", BW'(seen_q[1]), BW'(1));
      check("t1_addr2", BW'(seen_q[2]), BW'(3));
      check("t1_addr3", BW'(seen_q[3]), BW'(4));
    end

    // bottom-right corner, three pads
    do_fetch(16'd0, 2, 2, 3, 3, 1'b0, dc);
    check("t2_done_cyc", BW'(dc), BW'(6));
    lit = {16'd0, 16'd0, 16'd0, 16'd23};
    check("t2_block", block, lit);
    check("t2_nreads", BW'(seen_q.size()), BW'(1));
    if (seen_q.size() == 1) check("t2_addr", BW'(seen_q[0]), BW'(8));

    // transpose, origin (0,1)
    do_fetch(16'd0, 0, 1, 3, 3, 1'b1, dc);
    check("t3_done_cyc", BW'(dc), BW'(6));
    lit = {16'd13, 16'd3, 16'd12, 16'd2};
    check("t3_block", block, lit);

    // start held during busy: one fetch only
    @(negedge clk);
    d0 = done_cnt;
    for (int k = 0; k < 7; k++) begin
      drive_req(16'd0, 0, 0, 3, 3, 1'b0);
      @(negedge clk);
    end
    start = 1'b0;
    repeat (10) @(negedge clk);
    check("t4_one_done", BW'(done_cnt - d0), BW'(1));

    // reset in cycle t+3 of a fetch
    @(negedge clk);
    drive_req(16'd0, 0, 0, 3, 3, 1'b0);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3;
    check("t5_en_before", BW'(mem_en), BW'(1));
    rst_n = 1'b0;
    exp_q.delete();
    last_addr = '0;
    exp_block = '0;
    prev_done = 1'b0;
    #1;
    check("t5_busy", BW'(busy), '0);
    check("t5_done", BW'(done), '0);
    check("t5_en", BW'(mem_en), '0);
    check("t5_addr", BW'(mem_addr), '0);
    check("t5_block", block, '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_fetch(16'd0, 0, 0, 3, 3, 1'b0, dc);
    lit = {16'd12, 16'd11, 16'd2, 16'd1};
    check("t5_refetch", block, lit);

    // zero columns: nothing read
    do_fetch(16'd0, 0, 0, 3, 0, 1'b0, dc);
    check("t6_done_cyc", BW'(dc), BW'(6));
    check("t6_nreads", BW'(seen_q.size()), BW'(0));
    check("t6_block", block, '0);

    // address wrap at the top of memory
    do_fetch(16'hFFFE, 0, 0, 3, 3, 1'b0, dc);
    check("t7_nreads", BW'(seen_q.size()), BW'(4));
    if (seen_q.size() == 4) begin
      check("t7_addr0", BW'(seen_q[0]), BW'(16'hFFFE));
      check("t7_addr2", BW'(seen_q[2]), BW'(16'h0001));
    end

    // partial edges, zero rows, coordinate overflow must not wrap
    do_fetch(16'd0, 1, 2, 3, 3, 1'b0, dc);
    do_fetch(16'd0, 0, 0, 0, 3, 1'b1, dc);
    check("t8_nreads", BW'(seen_q.size()), BW'(0));
    do_fetch(16'd7, 1022, 3, 1023, 5, 1'b0, dc);
    do_fetch(16'd0, 0, 1023, 2, 1000, 1'b0, dc);
    check("t9_nreads", BW'(seen_q.size()), BW'(0));
    do_fetch(16'd0, 1, 0, 3, 3, 1'b1, dc);

    repeat (4) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
